// File: rtl/par_frame_ctrl.sv
// par_frame_ctrl: frame sequencer for a polyphase parallel FIR front end.
// Collects N_PH samples per group into the datapath lanes and strobes
// par_load once per complete group. After frame_len data groups it appends
// FLUSH_GRP zero-padded groups so the filter tail drains. sof/eof mark the
// first and last group of the frame, and done pulses on the final group.
module par_frame_ctrl #(
  parameter int W_CNT     = 12,
  parameter int N_PH      = 6,
  parameter int FLUSH_GRP = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [W_CNT-1:0] frame_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             pad_en,
  output logic             par_load,
  output logic [W_CNT-1:0] grp_cnt,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic             done
);

  localparam int PH_W = (N_PH > 1) ? $clog2(N_PH) : 1;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(N_PH - 1);
  localparam logic [PH_W-1:0]  PH_ZERO   = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
  localparam logic [W_CNT:0]   FLUSH_EXT = (W_CNT + 1)'(FLUSH_GRP);
  localparam logic [W_CNT-1:0] CNT_ZERO  = {W_CNT{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PH_W-1:0]  ph_q;
  logic [W_CNT-1:0] len_q;
  logic [W_CNT-1:0] grp_cnt_q;
  logic             par_load_q;
  logic             sof_q;
  logic             eof_q;
  logic             done_q;

  // Group count after the group being completed now; one extra bit so the
  // comparison against data length plus flush groups cannot wrap.
  logic [W_CNT:0]   grp_inc_d;
  logic [W_CNT:0]   total_grp_d;
  logic             data_end_d;
  logic             frame_end_d;

  assign grp_inc_d   = {1'b0, grp_cnt_q} + (W_CNT + 1)'(1);
  assign total_grp_d = {1'b0, len_q} + FLUSH_EXT;
  assign data_end_d  = (grp_inc_d == {1'b0, len_q});
  assign frame_end_d = (grp_inc_d == total_grp_d);

  // Datapath controls follow the state directly so samples move the same cycle.
  assign in_ready = (state_q == S_RUN);
  assign pad_en   = (state_q == S_FLUSH);
  assign shift_en = ((state_q == S_RUN) && in_valid) || (state_q == S_FLUSH);
  assign busy     = (state_q != S_IDLE);

  assign par_load = par_load_q;
  assign sof      = sof_q;
  assign eof      = eof_q;
  assign done     = done_q;
  assign grp_cnt  = grp_cnt_q;

  // Frame sequencer: state, phase, group count and the registered strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ph_q       <= PH_ZERO;
      len_q      <= CNT_ZERO;
      grp_cnt_q  <= CNT_ZERO;
      par_load_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      par_load_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        // Cancel drops any group completing this cycle along with its strobes.
        state_q   <= S_IDLE;
        ph_q      <= PH_ZERO;
        grp_cnt_q <= CNT_ZERO;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (frame_len != CNT_ZERO)) begin
              len_q     <= frame_len;
              ph_q      <= PH_ZERO;
              grp_cnt_q <= CNT_ZERO;
              state_q   <= S_RUN;
            end
          end
          S_RUN, S_FLUSH: begin
            if (shift_en) begin
              if (ph_q == PH_LAST) begin
                ph_q       <= PH_ZERO;
                par_load_q <= 1'b1;
                grp_cnt_q  <= grp_inc_d[W_CNT-1:0];
                sof_q      <= (grp_cnt_q == CNT_ZERO);
                eof_q      <= frame_end_d;
                if (frame_end_d) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else if ((state_q == S_RUN) && data_end_d) begin
                  state_q <= S_FLUSH;
                end
              end else begin
                ph_q <= ph_q + PH_ONE;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            ph_q    <= PH_ZERO;
          end
        endcase
      end
    end
  end

endmodule
